debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_unit.sv | 187 ++++++++++++++++++
 tb/tb_debug_unit.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// debug_unit -- UART debug monitor: program load, run/step control, register dump
// Revision 1.0
`default_nettype none

module debug_unit #(
  parameter int          IMEM_ADDR_W = 8,
  parameter int          DUMP_WORDS  = 33,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             i_rx_data,
  input  logic                   is_rx_done,
  input  logic                   is_tx_done,
  output logic [7:0]             o_tx_data,
  output logic                   os_tx_start,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_data,
  output logic                   o_cpu_enable,
  output logic                   o_cpu_rst,
  input  logic                   i_halt,
  output logic [5:0]             o_dbg_addr,
  input  logic [31:0]            i_dbg_data,
  output logic                   o_busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_STEP    = 3'd3,
    S_DUMP_RD = 3'd4,
    S_DUMP_TX = 3'd5,
    S_DUMP_WT = 3'd6
  } state_t;

  localparam logic [7:0] C_CMD_LOAD = 8'h01;
  localparam logic [7:0] C_CMD_RUN  = 8'h02;
  localparam logic [7:0] C_CMD_STEP = 8'h03;
  localparam logic [5:0] C_LAST_IDX = 6'(DUMP_WORDS - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_byte_cnt;
  logic [23:0]            r_word_buf;
  logic [IMEM_ADDR_W-1:0] r_waddr;
  logic                   r_imem_we;
  logic [IMEM_ADDR_W-1:0] r_imem_addr;
  logic [31:0]            r_imem_data;
  logic                   r_halt_load;
  logic                   r_cpu_rst;
  logic [5:0]             r_dump_idx;
  logic                   r_rd_phase;
  logic [31:0]            r_dump_word;
  logic [1:0]             r_tx_byte;

  logic                   w_load_done;
  logic [31:0]            w_load_word;

  assign w_load_done = (r_state == S_LOAD) && is_rx_done && (r_byte_cnt == 2'd3);
  assign w_load_word = {i_rx_data, r_word_buf};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (is_rx_done) begin
          case (i_rx_data)
            C_CMD_LOAD: w_next = S_LOAD;
            C_CMD_RUN:  w_next = S_RUN;
            C_CMD_STEP: w_next = S_STEP;
            default:    w_next = S_IDLE;
          endcase
        end
      end
      S_LOAD: begin
        if (w_load_done && (w_load_word == HALT_WORD)) w_next = S_IDLE;
      end
      S_RUN: begin
        if (i_halt) w_next = S_DUMP_RD;
      end
      S_STEP:    w_next = S_DUMP_RD;
      // Second read cycle captures the word the debug port returns for this address.
      S_DUMP_RD: begin
        if (r_rd_phase) w_next = S_DUMP_TX;
      end
      S_DUMP_TX: w_next = S_DUMP_WT;
      S_DUMP_WT: begin
        if (is_tx_done) begin
          if (r_tx_byte != 2'd3)            w_next = S_DUMP_TX;
          else if (r_dump_idx == C_LAST_IDX) w_next = S_IDLE;
          else                               w_next = S_DUMP_RD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_byte_cnt  <= '0;
      r_word_buf  <= '0;
      r_waddr     <= '0;
      r_imem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_imem_data <= '0;
      r_halt_load <= 1'b0;
      r_cpu_rst   <= 1'b0;
      r_dump_idx  <= '0;
      r_rd_phase  <= 1'b0;
      r_dump_word <= '0;
      r_tx_byte   <= '0;
    end else begin
      r_state     <= w_next;
      r_imem_we   <= 1'b0;
      r_halt_load <= 1'b0;
      r_cpu_rst   <= r_halt_load;
      case (r_state)
        S_IDLE: begin
          if (is_rx_done && (i_rx_data == C_CMD_LOAD)) begin
            r_byte_cnt <= '0;
            r_waddr    <= '0;
          end
        end
        S_LOAD: begin
          if (is_rx_done) begin
            if (r_byte_cnt == 2'd3) begin
              r_imem_we   <= 1'b1;
              r_imem_addr <= r_waddr;
              r_imem_data <= w_load_word;
              r_waddr     <= r_waddr + 1'b1;
              r_byte_cnt  <= '0;
              r_halt_load <= (w_load_word == HALT_WORD);
            end else begin
              case (r_byte_cnt)
                2'd0:    r_word_buf[7:0]   <= i_rx_data;
                2'd1:    r_word_buf[15:8]  <= i_rx_data;
                default: r_word_buf[23:16] <= i_rx_data;
              endcase
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
        S_RUN, S_STEP: begin
          r_dump_idx <= '0;
          r_rd_phase <= 1'b0;
          r_tx_byte  <= '0;
        end
        S_DUMP_RD: begin
          if (r_rd_phase) begin
            r_dump_word <= i_dbg_data;
            r_rd_phase  <= 1'b0;
            r_tx_byte   <= '0;
          end else begin
            r_rd_phase <= 1'b1;
          end
        end
        S_DUMP_WT: begin
          if (is_tx_done) begin
            if (r_tx_byte == 2'd3) begin
              r_tx_byte  <= '0;
              r_dump_idx <= (r_dump_idx == C_LAST_IDX) ? 6'd0 : r_dump_idx + 1'b1;
            end else begin
              r_tx_byte <= r_tx_byte + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = !rst && (r_state != S_IDLE);
  assign o_cpu_enable = !rst && (((r_state == S_RUN) && !i_halt) || (r_state == S_STEP));
  assign os_tx_start  = !rst && (r_state == S_DUMP_TX);
  assign o_tx_data    = rst ? 8'h00 : r_dump_word[{r_tx_byte, 3'b000} +: 8];
  assign o_cpu_rst    = rst | r_cpu_rst;
  assign o_dbg_addr   = rst ? 6'd0 : r_dump_idx;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_data  = r_imem_data;

endmodule

`default_nettype wire

// File: tb/tb_debug_unit.sv
// tb_debug_unit -- randomized self-checking bench for debug_unit
// Revision 1.0
`default_nettype none

module tb_debug_unit;

  localparam int          IMEM_ADDR_W = 8;
  localparam int          DUMP_WORDS  = 33;
  localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;

  logic                   clk;
  logic                   rst;
  logic [7:0]             i_rx_data;
  logic                   is_rx_done;
  logic                   is_tx_done;
  logic [7:0]             o_tx_data;
  logic                   os_tx_start;
  logic                   o_imem_we;
  logic [IMEM_ADDR_W-1:0] o_imem_addr;
  logic [31:0]            o_imem_data;
  logic                   o_cpu_enable;
  logic                   o_cpu_rst;
  logic                   i_halt;
  logic [5:0]             o_dbg_addr;
  logic [31:0]            i_dbg_data;
  logic                   o_busy;

  debug_unit #(
    .IMEM_ADDR_W(IMEM_ADDR_W),
    .DUMP_WORDS (DUMP_WORDS),
    .HALT_WORD  (HALT_WORD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (i_rx_data),
    .is_rx_done  (is_rx_done),
    .is_tx_done  (is_tx_done),
    .o_tx_data   (o_tx_data),
    .os_tx_start (os_tx_start),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_data (o_imem_data),
    .o_cpu_enable(o_cpu_enable),
    .o_cpu_rst   (o_cpu_rst),
    .i_halt      (i_halt),
    .o_dbg_addr  (o_dbg_addr),
    .i_dbg_data  (i_dbg_data),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Debug register file: registered read, data valid the cycle after the address.
  logic [31:0] dbg_mem [64];
  initial begin
    i_dbg_data = '0;
    forever begin
      @(posedge clk);
      i_dbg_data <= dbg_mem[o_dbg_addr];
    end
  end

  // Observed activity, plus a UART transmitter that acknowledges each byte after a random delay.
  logic [39:0] wq[$];
  logic [7:0]  txq[$];
  logic [31:0] load_q[$];
  int          en_cnt, crst_cnt, busy_cnt, overlap_err, hold_err;
  int          cyc, cyc_halt_we, cyc_crst;
  bit          tx_wait;
  logic [7:0]  tx_hold;
  int          tx_delay;

  initial begin
    is_tx_done = 1'b0;
    cyc = 0;
    tx_wait = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (o_cpu_enable) en_cnt++;
        if (o_imem_we) begin
          wq.push_back({o_imem_addr, o_imem_data});
          if (o_imem_data == HALT_WORD) cyc_halt_we = cyc;
        end
        if (o_cpu_rst) begin
          crst_cnt++;
          cyc_crst = cyc;
        end
        if (o_busy) busy_cnt++;
      end
      if (is_tx_done) is_tx_done = 1'b0;
      if (rst) begin
        tx_wait = 1'b0;
      end else if (os_tx_start) begin
        if (tx_wait) overlap_err++;
        txq.push_back(o_tx_data);
        tx_hold  = o_tx_data;
        tx_wait  = 1'b1;
        tx_delay = $urandom_range(0, 3);
      end else if (tx_wait) begin
        if (o_tx_data !== tx_hold) hold_err++;
        if (tx_delay == 0) begin
          is_tx_done = 1'b1;
          tx_wait    = 1'b0;
        end else begin
          tx_delay--;
        end
      end
    end
  end

  task automatic clear_mon();
    wq.delete();
    txq.delete();
    en_cnt = 0; crst_cnt = 0; busy_cnt = 0; overlap_err = 0; hold_err = 0;
    cyc_halt_we = -1; cyc_crst = -2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data  = b;
    is_rx_done = 1'b1;
    @(negedge clk);
    is_rx_done = 1'b0;
    i_rx_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  // Rx strobes injected while waiting are command bytes that must be ignored.
  task automatic wait_idle(input string tag, input int budget, input bit noise);
    int k = 0;
    while (o_busy && k < budget) begin
      @(negedge clk);
      if (noise) begin
        is_rx_done = ($urandom_range(0, 3) == 0);
        i_rx_data  = 8'($urandom_range(1, 3));
      end
      k++;
    end
    is_rx_done = 1'b0;
    check_value({tag, "_idle_in_time"}, 64'(k < budget), 64'd1);
  endtask

  task automatic randomize_dbg();
    for (int i = 0; i < 64; i++) dbg_mem[i] = $urandom;
  endtask

  task automatic check_dump(input string tag);
    check_value({tag, "_byte_count"}, 64'(txq.size()), 64'(DUMP_WORDS * 4));
    for (int i = 0; i < txq.size() && i < DUMP_WORDS * 4; i++)
      check_value({tag, "_byte"}, 64'(txq[i]), 64'((dbg_mem[i / 4] >> (8 * (i % 4))) & 32'hFF));
    check_value({tag, "_start_before_ack"}, 64'(overlap_err), 64'd0);
    check_value({tag, "_tx_data_unstable"}, 64'(hold_err), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_busy"}, 64'(o_busy), 64'd0);
    check_value({tag, "_cpu_rst"}, 64'(o_cpu_rst), 64'd1);
    check_value({tag, "_cpu_en"}, 64'(o_cpu_enable), 64'd0);
    check_value({tag, "_tx"}, {55'd0, os_tx_start, o_tx_data}, 64'd0);
    check_value({tag, "_imem"}, {23'd0, o_imem_we, o_imem_addr, o_imem_data}, 64'd0);
    check_value({tag, "_dbg_addr"}, 64'(o_dbg_addr), 64'd0);
  endtask

  // Sends LOAD followed by every word in load_q, LSB first, with random gaps.
  task automatic do_load(input string tag, input bit expect_halt);
    logic [7:0] a;
    clear_mon();
    send_byte(8'h01, $urandom_range(0, 2));
    foreach (load_q[w])
      for (int b = 0; b < 4; b++) send_byte(8'(load_q[w] >> (8 * b)), $urandom_range(0, 2));
    repeat (3) @(negedge clk);
    check_value({tag, "_write_count"}, 64'(wq.size()), 64'(load_q.size()));
    for (int i = 0; i < wq.size() && i < load_q.size(); i++) begin
      a = 8'(i % (1 << IMEM_ADDR_W));
      check_value({tag, "_write"}, 64'(wq[i]), 64'({a, load_q[i]}));
    end
    if (expect_halt) begin
      check_value({tag, "_cpu_rst_cycles"}, 64'(crst_cnt), 64'd1);
      check_value({tag, "_cpu_rst_after_write"}, 64'(cyc_crst), 64'(cyc_halt_we + 1));
      check_value({tag, "_back_idle"}, 64'(o_busy), 64'd0);
    end
    check_value({tag, "_cpu_frozen"}, 64'(en_cnt), 64'd0);
  endtask

  task automatic run_test(input int n);
    clear_mon();
    randomize_dbg();
    i_halt = (n == 0);
    send_byte(8'h02, 0);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1 i_halt = 1'b1;
    end
    wait_idle("run", 3000, 1'b1);
    check_value("run_enabled_cycles", 64'(en_cnt), 64'(n));
    check_dump("run_dump");
    check_value("run_no_imem_write", 64'(wq.size()), 64'd0);
    i_halt = 1'b0;
  endtask

  task automatic step_test(input string tag);
    clear_mon();
    randomize_dbg();
    dbg_mem[0] = 32'hDEADBEEF;
    i_halt = 1'($urandom_range(0, 1));
    send_byte(8'h03, 0);
    wait_idle(tag, 3000, 1'b1);
    check_value({tag, "_enabled_cycles"}, 64'(en_cnt), 64'd1);
    if (txq.size() >= 4)
      check_value({tag, "_word0_bytes"}, 64'({txq[0], txq[1], txq[2], txq[3]}), 64'h00000000_EFBEADDE);
    check_dump(tag);
    i_halt = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  g;
    int          k;
    rst = 1'b1; is_rx_done = 1'b0; i_rx_data = 8'h00; i_halt = 1'b0;
    for (int i = 0; i < 64; i++) dbg_mem[i] = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load_q = '{32'h04030201, 32'h20C04080, HALT_WORD};
    do_load("load_basic", 1'b1);

    for (int t = 0; t < 4; t++) begin
      clear_mon();
      g = (t == 0) ? 8'h07 : (t == 1) ? 8'h00 : 8'($urandom_range(4, 255));
      send_byte(g, 0);
      repeat (4) @(negedge clk);
      check_value("bad_cmd_busy", 64'(busy_cnt), 64'd0);
      check_value("bad_cmd_activity", 64'(wq.size() + txq.size() + en_cnt + crst_cnt), 64'd0);
    end

    run_test(5);
    run_test(0);
    run_test($urandom_range(1, 20));
    step_test("step");

    // Reset in the middle of a LOAD word discards the partial bytes.
    clear_mon();
    send_byte(8'h01, 0);
    send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid_load");
    rst = 1'b0;
    w = $urandom;
    if (w == HALT_WORD) w = 32'h0;
    load_q = '{w};
    do_load("reload", 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a dump, then a full dump must start again from word 0.
    clear_mon();
    randomize_dbg();
    send_byte(8'h03, 0);
    k = 0;
    while (txq.size() < 6 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check_value("mid_dump_reached", 64'(k < 500), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_mid_dump");
    rst = 1'b0;
    @(negedge clk);
    check_value("after_rst_idle", 64'(o_busy), 64'd0);
    step_test("step_after_rst");

    // 2^IMEM_ADDR_W + 1 words: the final (HALT) word wraps to address 0.
    load_q.delete();
    for (int i = 0; i < (1 << IMEM_ADDR_W); i++) begin
      w = $urandom;
      if (w == HALT_WORD) w = 32'h0;
      load_q.push_back(w);
    end
    load_q.push_back(HALT_WORD);
    do_load("load_wrap", 1'b1);
    if (wq.size() > (1 << IMEM_ADDR_W))
      check_value("wrap_last_addr", 64'(wq[1 << IMEM_ADDR_W][39:32]), 64'd0);

    run_test($urandom_range(1, 10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, required finish before 900000");
    $fatal(1);
  end

endmodule

`default_nettype wire
